router_reg_param: RTL and testbench

Parametrised packet-datapath register for the router, sitting between the input port and the destination FIFOs under control of the router FSM. It latches the header, forwards payload bytes one cycle after arrival, and holds one byte in a hold register while the target FIFO is full. It accumulates a configurable running parity and flags parity and length errors against the length field carried in the header.

---
 rtl/router_reg_param.sv | 175 +++++++++++++++++
 tb/tb_router_reg_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg_param.sv
// Router packet-datapath register: latches the header, forwards payload one cycle
// late, buffers one byte while the FIFO is full, and checks parity and length.
module router_reg_param #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int LEN_W       = 6,
  parameter int NUM_DEST    = 3,
  parameter int PARITY_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              error,
  output logic              len_error
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] header_reg;
  logic [DATA_W-1:0] hold_reg;
  logic              hold_valid;
  logic              hold_is_par;
  logic [DATA_W-1:0] int_par;
  logic [DATA_W-1:0] pkt_par;
  logic [CNT_W-1:0]  byte_cnt;
  logic              parity_done_q;

  logic [ADDR_W-1:0] dest;
  logic              dest_ok;
  logic [LEN_W-1:0]  hdr_len;
  logic [CNT_W-1:0]  cnt_next;
  logic              take_hdr;
  logic              do_lfd;
  logic              do_data;
  logic              do_par;
  logic              do_drain;
  logic              check_now;

  // In full_state nothing moves: dout and the hold buffer simply persist.
  logic unused_full;
  assign unused_full = full_state;

  function automatic logic [DATA_W-1:0] par_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    if (PARITY_MODE == 1) return a + b;
    else                  return a ^ b;
  endfunction

  assign dest      = din[ADDR_W-1:0];
  assign dest_ok   = (32'(dest) < 32'(NUM_DEST));
  assign hdr_len   = header_reg[ADDR_W+LEN_W-1:ADDR_W];
  assign cnt_next  = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + CNT_W'(1);
  assign check_now = parity_done && !parity_done_q;

  // Priority decode of the one-hot state inputs.
  always_comb begin
    take_hdr = 1'b0;
    do_lfd   = 1'b0;
    do_data  = 1'b0;
    do_par   = 1'b0;
    do_drain = 1'b0;
    if (detect_add) begin
      take_hdr = pkt_valid && dest_ok;
    end else if (lfd_state) begin
      do_lfd = 1'b1;
    end else if (ld_state) begin
      do_data = pkt_valid;
      do_par  = !pkt_valid;
    end else if (laf_state) begin
      do_drain = hold_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      header_reg <= '0;
    end else if (take_hdr) begin
      header_reg <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      hold_reg    <= '0;
      hold_valid  <= 1'b0;
      hold_is_par <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (take_hdr) begin
        hold_valid <= 1'b0;
      end else if (do_lfd) begin
        dout       <= header_reg;
        dout_valid <= 1'b1;
      end else if (do_data || do_par) begin
        if (!fifo_full) begin
          dout       <= din;
          dout_valid <= 1'b1;
        end else begin
          hold_reg    <= din;
          hold_valid  <= 1'b1;
          hold_is_par <= do_par;
        end
      end else if (do_drain) begin
        dout       <= hold_reg;
        dout_valid <= 1'b1;
        hold_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_par  <= '0;
      pkt_par  <= '0;
      byte_cnt <= '0;
    end else if (take_hdr) begin
      int_par  <= '0;
      pkt_par  <= '0;
      byte_cnt <= '0;
    end else if (do_lfd) begin
      int_par <= par_f('0, header_reg);
    end else if (do_data) begin
      int_par  <= par_f(int_par, din);
      byte_cnt <= cnt_next;
    end else if (do_par && !fifo_full) begin
      pkt_par <= din;
    end else if (do_drain && hold_is_par) begin
      pkt_par <= hold_reg;
    end
  end

  // Checks run one cycle after parity_done rises; a new header wins over them.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_done   <= 1'b0;
      parity_done_q <= 1'b0;
      low_pkt_valid <= 1'b0;
      error         <= 1'b0;
      len_error     <= 1'b0;
    end else begin
      parity_done_q <= parity_done;
      if (check_now) begin
        error     <= (int_par != pkt_par);
        len_error <= (byte_cnt != {1'b0, hdr_len});
      end
      if (take_hdr) begin
        parity_done <= 1'b0;
        error       <= 1'b0;
        len_error   <= 1'b0;
      end else if (do_par && !fifo_full) begin
        parity_done <= 1'b1;
      end else if (do_drain && hold_is_par) begin
        parity_done <= 1'b1;
      end
      if (do_par) low_pkt_valid <= 1'b1;
      if (rst_int_reg) low_pkt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_reg_param.sv
// Directed bench for router_reg_param: a packet-level model (payload queue, folded
// parity) checked every cycle on XOR and SUM instances, plus literal expectations.
module tb_router_reg_param;
  logic clk = 1'b0;
  logic rst, pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] din;
  logic [7:0] dout0, dout1;
  logic dv0, dv1, pd0, pd1, low0, low1, err0, err1, lerr0, lerr1;
  int n_tests = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  localparam logic [4:0] ST_IDLE = 5'b00000;
  localparam logic [4:0] ST_DET  = 5'b10000;
  localparam logic [4:0] ST_LFD  = 5'b01000;
  localparam logic [4:0] ST_LD   = 5'b00100;
  localparam logic [4:0] ST_LAF  = 5'b00010;

  always #5 clk = ~clk;

  router_reg_param #(.PARITY_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout0), .dout_valid(dv0), .parity_done(pd0), .low_pkt_valid(low0),
    .error(err0), .len_error(lerr0));

  router_reg_param #(.PARITY_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout1), .dout_valid(dv1), .parity_done(pd1), .low_pkt_valid(low1),
    .error(err1), .len_error(lerr1));

  // Packet-level model: accepted payload kept as a queue, parity folded on demand.
  logic [7:0] m_hdr, m_par, m_held, m_dout;
  logic m_held_v, m_held_p, m_dv, m_pd, m_pd_prev, m_low, m_lerr;
  logic m_err [2];
  logic [7:0] m_bytes [$];
  logic [7:0] cap [$];

  function automatic logic [7:0] fold(input int mode);
    logic [7:0] acc;
    acc = m_hdr;
    foreach (m_bytes[i]) acc = (mode == 1) ? acc + m_bytes[i] : acc ^ m_bytes[i];
    return acc;
  endfunction

  task automatic model_clear();
    m_hdr = 0; m_par = 0; m_held = 0; m_dout = 0;
    m_held_v = 0; m_held_p = 0; m_dv = 0; m_pd = 0; m_pd_prev = 0;
    m_low = 0; m_lerr = 0; m_err[0] = 0; m_err[1] = 0;
    m_bytes.delete();
  endtask

  task automatic model_step();
    int cnt;
    logic pd_old;
    if (rst) begin
      model_clear();
      return;
    end
    pd_old = m_pd;
    if (m_pd && !m_pd_prev) begin
      cnt = (m_bytes.size() > 127) ? 127 : m_bytes.size();
      for (int k = 0; k < 2; k++) m_err[k] = (fold(k) != m_par);
      m_lerr = (cnt != int'(m_hdr[7:2]));
    end
    m_pd_prev = pd_old;
    m_dv = 0;
    if (detect_add) begin
      if (pkt_valid && din[1:0] < 2'd3) begin
        m_hdr = din; m_bytes.delete(); m_pd = 0; m_par = 0;
        m_err[0] = 0; m_err[1] = 0; m_lerr = 0; m_held_v = 0;
      end
    end else if (lfd_state) begin
      m_dout = m_hdr; m_dv = 1;
    end else if (ld_state) begin
      if (pkt_valid) m_bytes.push_back(din);
      else m_low = 1;
      if (!fifo_full) begin
        m_dout = din; m_dv = 1;
        if (!pkt_valid) begin m_par = din; m_pd = 1; end
      end else begin
        m_held = din; m_held_v = 1; m_held_p = !pkt_valid;
      end
    end else if (laf_state && m_held_v) begin
      m_dout = m_held; m_dv = 1; m_held_v = 0;
      if (m_held_p) begin m_par = m_held; m_pd = 1; end
    end
    if (rst_int_reg) m_low = 0;
  endtask

  always @(posedge clk) model_step();

  task automatic cmp_out(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: {dout,dv,pd,low,err,lerr} actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_seq(input string name, input logic [7:0] exp [$]);
    bit bad;
    bad = (cap.size() != exp.size());
    if (!bad) foreach (exp[i]) if (cap[i] !== exp[i]) bad = 1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: actual=%p required=%p", name, cap, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_out("cyc_dut0", {dout0, dv0, pd0, low0, err0, lerr0}, {m_dout, m_dv, m_pd, m_low, m_err[0], m_lerr});
      cmp_out("cyc_dut1", {dout1, dv1, pd1, low1, err1, lerr1}, {m_dout, m_dv, m_pd, m_low, m_err[1], m_lerr});
      if (dv0) cap.push_back(dout0);
    end
  end

  task automatic drv(input logic [4:0] st, input logic pv, input logic [7:0] d,
                     input logic ff, input logic rir);
    {detect_add, lfd_state, ld_state, laf_state, full_state} = st;
    pkt_valid = pv; din = d; fifo_full = ff; rst_int_reg = rir;
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl [$],
                          input logic [7:0] par, input int full_idx);
    cap.delete();
    drv(ST_DET, 1, hdr, 0, 0);
    drv(ST_LFD, 1, pl[0], 0, 0);
    foreach (pl[i]) begin
      if (i == full_idx) begin
        drv(ST_LD, 1, pl[i], 1, 0);
        chk("full_no_dv", 32'(dv0), 32'(0));
        drv(ST_LAF, 1, pl[i], 0, 0);
        chk("held_out", 32'({dv0, dout0}), 32'({1'b1, pl[i]}));
      end else begin
        drv(ST_LD, 1, pl[i], 0, 0);
      end
    end
    drv(ST_LD, 0, par, 0, 0);
    drv(ST_IDLE, 0, 8'h00, 0, 0);
    drv(ST_IDLE, 0, 8'h00, 0, 0);
  endtask

  initial begin
    logic [7:0] pl3 [$];
    logic [7:0] pl2 [$];
    logic [7:0] big [$];
    logic [7:0] seq5 [$];
    pl3 = {8'h11, 8'h22, 8'h33};
    pl2 = {8'h11, 8'h22};
    seq5 = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    for (int i = 0; i < 128; i++) big.push_back(8'(i));
    model_clear();
    rst = 1;
    {detect_add, lfd_state, ld_state, laf_state, full_state} = 5'b0;
    pkt_valid = 0; din = 0; fifo_full = 0; rst_int_reg = 0;
    @(negedge clk);
    cmp_en = 1;
    chk("reset_dut0", 32'({dout0, dv0, pd0, low0, err0, lerr0}), 32'(0));
    chk("reset_dut1", 32'({dout1, dv1, pd1, low1, err1, lerr1}), 32'(0));
    rst = 0;
    drv(ST_IDLE, 0, 8'h00, 0, 0);

    // 1: good XOR packet
    send_pkt(8'h0D, pl3, 8'h0D, -1);
    chk_seq("t1_seq", seq5);
    chk("t1_pd", 32'(pd0), 32'(1));
    chk("t1_err0", 32'(err0), 32'(0));
    chk("t1_lerr", 32'(lerr0), 32'(0));
    chk("t1_err1", 32'(err1), 32'(1));

    // 2: bad parity, sticky until next valid header
    send_pkt(8'h0D, pl3, 8'h0C, -1);
    chk("t2_err0", 32'(err0), 32'(1));
    chk("t2_err1", 32'(err1), 32'(1));
    chk("t2_lerr", 32'(lerr0), 32'(0));
    repeat (3) drv(ST_IDLE, 0, 8'h00, 0, 0);
    chk("t2_sticky", 32'(err0), 32'(1));
    drv(ST_DET, 1, 8'h0D, 0, 0);
    chk("t2_clear", 32'({err0, pd0}), 32'(0));
    drv(ST_IDLE, 0, 8'h00, 0, 0);

    // 3: sum parity
    send_pkt(8'h0D, pl3, 8'h73, -1);
    chk("t3_err1_ok", 32'(err1), 32'(0));
    chk("t3_err0_bad", 32'(err0), 32'(1));
    send_pkt(8'h0D, pl3, 8'h0D, -1);
    chk("t3_err1_bad", 32'(err1), 32'(1));

    // 4: fifo full on 0x22
    send_pkt(8'h0D, pl3, 8'h0D, 1);
    chk_seq("t4_seq", seq5);
    chk("t4_err", 32'({err0, lerr0}), 32'(0));

    // 5: parity byte while full
    drv(ST_IDLE, 0, 8'h00, 0, 1);
    chk("t5_low_clr", 32'(low0), 32'(0));
    drv(ST_DET, 1, 8'h0D, 0, 0);
    drv(ST_LFD, 1, 8'h11, 0, 0);
    drv(ST_LD, 1, 8'h11, 0, 0);
    drv(ST_LD, 1, 8'h22, 0, 0);
    drv(ST_LD, 1, 8'h33, 0, 0);
    drv(ST_LD, 0, 8'h0D, 1, 0);
    chk("t5_low_pd_dv", 32'({low0, pd0, dv0}), 32'(3'b100));
    drv(ST_LAF, 0, 8'h00, 0, 0);
    chk("t5_drain", 32'({pd0, dv0, dout0}), 32'({2'b11, 8'h0D}));
    drv(ST_IDLE, 0, 8'h00, 0, 0);
    drv(ST_IDLE, 0, 8'h00, 0, 0);
    chk("t5_err", 32'({err0, lerr0}), 32'(0));
    drv(ST_IDLE, 0, 8'h00, 0, 1);
    chk("t5_rst_int", 32'(low0), 32'(0));

    // 6a: invalid destination leaves header and flags untouched
    drv(ST_DET, 1, 8'h0F, 0, 0);
    drv(ST_LFD, 1, 8'h00, 0, 0);
    chk("t6_bad_dest", 32'({dv0, dout0, pd0}), 32'({1'b1, 8'h0D, 1'b1}));
    drv(ST_IDLE, 0, 8'h00, 0, 0);

    // 6b: short packet
    send_pkt(8'h0D, pl2, 8'h3E, -1);
    chk("t6_short", 32'({err0, lerr0}), 32'(2'b01));

    // 6c: byte counter saturates instead of wrapping to the header length 0
    send_pkt(8'h01, big, 8'h00, -1);
    chk("t6_sat", 32'(lerr0), 32'(1));

    // 6d: reset mid-payload
    drv(ST_DET, 1, 8'h0D, 0, 0);
    drv(ST_LFD, 1, 8'h11, 0, 0);
    drv(ST_LD, 1, 8'h11, 0, 0);
    rst = 1;
    drv(ST_LD, 1, 8'h22, 0, 0);
    chk("t6_rst0", 32'({dout0, dv0, pd0, low0, err0, lerr0}), 32'(0));
    chk("t6_rst1", 32'({dout1, dv1, pd1, low1, err1, lerr1}), 32'(0));
    rst = 0;
    drv(ST_IDLE, 0, 8'h00, 0, 0);
    chk("t6_idle", 32'(dv0), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
